// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data memory controller.
// Holds FSM states, funct3 access codes, byte-enable masks and legality check.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic access_legal(
        input logic       is_store,
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic ok;
        case (f3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~a[0];
            F3_LW:         ok = (a == 2'b00);
            default:       ok = 1'b0;
        endcase
        // stores have no unsigned variants
        if (is_store && f3[2]) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication/byte enables and load select/extend.
// Purely combinational; store and load sides are independent.
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = BE_WORD;
        st_wdata = st_data;
        case (st_funct3)
            F3_SB: begin
                st_be    = BE_BYTE << st_addr;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_SH: begin
                st_be    = BE_HALF << st_addr;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = BE_WORD;
                st_wdata = st_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_word[7:0];
        case (ld_addr)
            2'd0: ld_byte = ld_word[7:0];
            2'd1: ld_byte = ld_word[15:8];
            2'd2: ld_byte = ld_word[23:16];
            2'd3: ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
        ld_half = ld_addr[1] ? ld_word[31:16] : ld_word[15:0];
    end

    always_comb begin
        ld_data = ld_word;
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {24'd0, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory controller: stalls the pipeline while a single
// registered bus transaction runs, with timeout and misalignment detection.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        BusErrM
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [2:0]  f3_q;
    logic [1:0]  alo_q;
    logic        access, legal, issue;
    logic        done_ok, done_err;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;

    assign access = MemReadM | MemWriteM;
    assign legal  = access_legal(MemWriteM, funct3M, ALUResultM[1:0]);
    assign issue  = (state_q == ST_IDLE) && access && legal;

    mem_lane_align u_align (
        .st_funct3 (funct3M),
        .st_addr   (ALUResultM[1:0]),
        .st_data   (WriteDataM),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .ld_funct3 (f3_q),
        .ld_addr   (alo_q),
        .ld_word   (bus_rdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        done_ok  = 1'b0;
        done_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (access && legal) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (bus_ack || bus_err) begin
                    state_d  = ST_DONE;
                    done_err = bus_err;
                    done_ok  = ~bus_err;
                end else if (cnt_q == TO_LAST) begin
                    state_d  = ST_DONE;
                    done_err = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // reset gating keeps both strobes low while the core is held in reset
    always_comb begin
        StallM    = rst & (issue | (state_q == ST_BUSY));
        MisalignM = rst & (state_q == ST_IDLE) & access & ~legal;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            f3_q      <= 3'd0;
            alo_q     <= 2'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_be    <= BE_NONE;
            ReadDataM <= 32'd0;
            BusErrM   <= 1'b0;
        end else begin
            state_q <= state_d;
            BusErrM <= done_err;
            if (issue) begin
                bus_req   <= 1'b1;
                bus_we    <= MemWriteM;
                bus_addr  <= {ALUResultM[31:2], 2'b00};
                bus_be    <= MemWriteM ? st_be : BE_WORD;
                bus_wdata <= MemWriteM ? st_wdata : 32'd0;
                f3_q      <= funct3M;
                alo_q     <= ALUResultM[1:0];
                cnt_q     <= 8'd0;
            end
            if (state_q == ST_BUSY) begin
                if (state_d == ST_DONE) begin
                    bus_req <= 1'b0;
                    bus_we  <= 1'b0;
                    bus_be  <= BE_NONE;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
            if (done_ok && !bus_we) ReadDataM <= ld_data;
        end
    end

endmodule
